// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C bus arbiter: FSM encoding, R/W constants and field widths.
package i2c_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_GAP   = 2'd3
   } arb_state_t;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   localparam int CHIP_W = 7;
   localparam int REG_W  = 8;
   localparam int DATA_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: picks the first set request at or after the start pointer.
module rr_arbiter #(
   parameter int N_REQ = 3,
   parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [PTR_W-1:0] grant_idx,
   output logic             any
);

   // Scan N_REQ positions starting at ptr, wrapping modulo N_REQ; first hit wins.
   always_comb begin
      logic [PTR_W:0]   sum_s;
      logic [PTR_W-1:0] idx_s;
      logic             hit_s;
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      sum_s     = '0;
      idx_s     = '0;
      hit_s     = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         sum_s = {1'b0, ptr} + (PTR_W+1)'(k);
         sum_s = (sum_s >= (PTR_W+1)'(N_REQ)) ? (sum_s - (PTR_W+1)'(N_REQ)) : sum_s;
         idx_s = sum_s[PTR_W-1:0];
         hit_s = ~any & req[idx_s];
         grant[idx_s] = grant[idx_s] | hit_s;
         grant_idx    = hit_s ? idx_s : grant_idx;
         any          = any | hit_s;
      end
   end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C master among N_REQ requesters with round-robin grant and an enforced idle gap.
// Define I2C_ARB_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYCLES clocks.
module i2c_bus_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int N_REQ          = 3,
   parameter int I2C_TXN_DELAY  = 600,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          req_rw,
   input  logic [CHIP_W*N_REQ-1:0]   req_chip_addr,
   input  logic [REG_W*N_REQ-1:0]    req_reg_addr,
   input  logic [DATA_W*N_REQ-1:0]   req_wr_data,
   output logic [N_REQ-1:0]          grant,
   output logic [N_REQ-1:0]          done,
   output logic                      ack_err,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      m_start,
   output logic                      m_rw,
   output logic [CHIP_W-1:0]         m_chip_addr,
   output logic [REG_W-1:0]          m_reg_addr,
   output logic [DATA_W-1:0]         m_wr_data,
   input  logic                      m_done,
   input  logic                      m_ack_err,
   input  logic [DATA_W-1:0]         m_rd_data
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int GAP_W = $clog2(I2C_TXN_DELAY + 1);

   arb_state_t          state_r;
   logic [PTR_W-1:0]    ptr_r;
   logic [GAP_W-1:0]    gap_cnt_r;
   logic [N_REQ-1:0]    rr_grant_s;
   logic [PTR_W-1:0]    rr_idx_s;
   logic                rr_any_s;
   logic [PTR_W-1:0]    next_ptr_s;
`ifdef I2C_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0]     to_cnt_r;
`endif

   rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr (
      .req       (req),
      .ptr       (ptr_r),
      .grant     (rr_grant_s),
      .grant_idx (rr_idx_s),
      .any       (rr_any_s)
   );

   // The pointer holds the index that gets first priority next time, i.e. one past the winner.
   assign next_ptr_s = (rr_idx_s == PTR_W'(N_REQ - 1)) ? '0 : (rr_idx_s + PTR_W'(1));

   // Arbiter FSM with all outputs registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         ptr_r       <= '0;
         gap_cnt_r   <= '0;
         grant       <= '0;
         done        <= '0;
         ack_err     <= 1'b0;
         rd_data     <= '0;
         m_start     <= 1'b0;
         m_rw        <= 1'b0;
         m_chip_addr <= '0;
         m_reg_addr  <= '0;
         m_wr_data   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
         to_cnt_r    <= '0;
`endif
      end else begin
         done    <= '0;
         ack_err <= 1'b0;
         m_start <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (rr_any_s) begin
                  grant       <= rr_grant_s;
                  ptr_r       <= next_ptr_s;
                  m_rw        <= req_rw[rr_idx_s];
                  m_chip_addr <= req_chip_addr[rr_idx_s*CHIP_W +: CHIP_W];
                  m_reg_addr  <= req_reg_addr[rr_idx_s*REG_W +: REG_W];
                  m_wr_data   <= req_wr_data[rr_idx_s*DATA_W +: DATA_W];
                  state_r     <= ST_ISSUE;
               end else begin
                  grant <= '0;
               end
            end
            ST_ISSUE: begin
               m_start <= 1'b1;
               state_r <= ST_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
               to_cnt_r <= '0;
`endif
            end
            ST_WAIT: begin
               if (m_done) begin
                  done      <= grant;
                  ack_err   <= m_ack_err;
                  rd_data   <= m_rd_data;
                  grant     <= '0;
                  gap_cnt_r <= '0;
                  state_r   <= ST_GAP;
`ifdef I2C_ARB_TIMEOUT_EN
               end else if (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  done      <= grant;
                  ack_err   <= 1'b1;
                  rd_data   <= '0;
                  grant     <= '0;
                  gap_cnt_r <= '0;
                  state_r   <= ST_GAP;
               end else begin
                  to_cnt_r  <= to_cnt_r + TO_W'(1);
               end
`else
               end else begin
                  state_r   <= ST_WAIT;
               end
`endif
            end
            ST_GAP: begin
               if (gap_cnt_r == GAP_W'(I2C_TXN_DELAY - 1)) begin
                  state_r <= ST_IDLE;
               end else begin
                  gap_cnt_r <= gap_cnt_r + GAP_W'(1);
               end
            end
            default: begin
               grant   <= '0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: stimulus pushes expected starts/completions, a monitor checks them.
module tb_i2c_bus_arbiter;
   import i2c_arb_pkg::*;

   localparam int N   = 3;
   localparam int DLY = 600;
`ifdef I2C_ARB_TIMEOUT_EN
   localparam int TO  = 100;
`else
   localparam int TO  = 1000000;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [2:0]    req = 3'b000;
   logic [2:0]    req_rw = 3'b000;
   logic [20:0]   req_chip_addr = 21'h0;
   logic [23:0]   req_reg_addr = 24'h0;
   logic [23:0]   req_wr_data = 24'h0;
   logic [2:0]    grant, done;
   logic          ack_err, m_start, m_rw;
   logic [7:0]    rd_data, m_reg_addr, m_wr_data;
   logic [6:0]    m_chip_addr;
   logic          m_done = 1'b0;
   logic          m_ack_err = 1'b0;
   logic [7:0]    m_rd_data = 8'h00;

   i2c_bus_arbiter #(.N_REQ(N), .I2C_TXN_DELAY(DLY), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .req(req), .req_rw(req_rw),
      .req_chip_addr(req_chip_addr), .req_reg_addr(req_reg_addr), .req_wr_data(req_wr_data),
      .grant(grant), .done(done), .ack_err(ack_err), .rd_data(rd_data),
      .m_start(m_start), .m_rw(m_rw), .m_chip_addr(m_chip_addr), .m_reg_addr(m_reg_addr),
      .m_wr_data(m_wr_data), .m_done(m_done), .m_ack_err(m_ack_err), .m_rd_data(m_rd_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] grant; logic rw; logic [6:0] chip; logic [7:0] ra; logic [7:0] wd;
      int cyc; bit lat;
   } start_t;
   typedef struct {
      logic [2:0] done; logic ack; logic [7:0] rd; int cyc;
   } done_t;

   start_t     sq[$];
   done_t      dq[$];
   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         last_done_cyc = 0;
   logic [7:0] last_rd = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT starts the master or completes a transaction.
   always @(negedge clk) begin : mon
      start_t es;
      done_t  ed;
      if (!reset) begin
         last_rd = 8'h00;
      end else begin
         if (m_start) begin
            if (sq.size() == 0) begin
               check("unexpected_start", 64'd1, 64'd0);
            end else begin
               es = sq.pop_front();
               check("start_fields", {grant, m_rw, m_chip_addr, m_reg_addr, m_wr_data},
                     {es.grant, es.rw, es.chip, es.ra, es.wd});
               if (es.cyc >= 0) check("start_cycle", cyc, es.cyc);
               if (es.lat) check("done_to_start", cyc - last_done_cyc, DLY + 2);
            end
         end
         if (|done) begin
            if (dq.size() == 0) begin
               check("unexpected_done", {ack_err, done}, 4'd0);
            end else begin
               ed = dq.pop_front();
               check("done_vec", done, ed.done);
               check("done_ack", ack_err, ed.ack);
               check("done_rd", rd_data, ed.rd);
               if (ed.cyc >= 0) check("done_cycle", cyc, ed.cyc);
               last_rd = ed.rd;
            end
            last_done_cyc = cyc;
         end else begin
            check("ack_idle", ack_err, 1'b0);
            check("rd_hold", rd_data, last_rd);
         end
      end
   end

   task automatic set_fields(input int i, input logic rw, input logic [6:0] c,
                             input logic [7:0] r, input logic [7:0] d);
      req_rw[i]             = rw;
      req_chip_addr[i*7 +: 7] = c;
      req_reg_addr[i*8 +: 8]  = r;
      req_wr_data[i*8 +: 8]   = d;
   endtask

   task automatic wait_start();
      bit ok = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (m_start) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("start_timeout", 64'd0, 64'd1);
   endtask

   task automatic pulse_done(input logic ack, input logic [7:0] rd);
      @(posedge clk); #1;
      m_done = 1'b1; m_ack_err = ack; m_rd_data = rd;
      @(posedge clk); #1;
      m_done = 1'b0; m_ack_err = 1'b0; m_rd_data = 8'h00;
   endtask

   task automatic wait_idle();
      repeat (DLY + 5) @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string name);
      check(name, {grant, done, m_start, ack_err, rd_data, m_rw, m_chip_addr, m_reg_addr, m_wr_data},
            64'd0);
   endtask

   initial begin : stim
      int s;
      bit seen;
      int nxt;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset_outputs");
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) @(posedge clk); #1;

      // Single write from requester 0.
      set_fields(0, RW_WRITE, 7'h39, 8'h41, 8'h10);
      req = 3'b001;
      sq.push_back('{3'b001, RW_WRITE, 7'h39, 8'h41, 8'h10, cyc + 2, 1'b0});
      wait_start();
      req = 3'b000;
      dq.push_back('{3'b001, 1'b0, 8'h00, -1});
      pulse_done(1'b0, 8'h00);
      wait_idle();

      // Read by requester 1; fields changed and req dropped while waiting must not matter.
      set_fields(1, RW_READ, 7'h50, 8'h42, 8'h00);
      req = 3'b010;
      sq.push_back('{3'b010, RW_READ, 7'h50, 8'h42, 8'h00, cyc + 2, 1'b0});
      wait_start();
      req = 3'b000;
      set_fields(1, RW_WRITE, 7'h11, 8'hFF, 8'h99);
      @(negedge clk);
      check("wait_hold", {grant, m_rw, m_chip_addr, m_reg_addr}, {3'b010, RW_READ, 7'h50, 8'h42});
      dq.push_back('{3'b010, 1'b0, 8'hA5, -1});
      pulse_done(1'b0, 8'hA5);
      repeat (10) @(posedge clk); #1;
      pulse_done(1'b1, 8'h3C);
      wait_idle();
      pulse_done(1'b1, 8'h3C);
      repeat (3) @(posedge clk); #1;

      // NACK from requester 2.
      set_fields(2, RW_WRITE, 7'h20, 8'h10, 8'h55);
      req = 3'b100;
      sq.push_back('{3'b100, RW_WRITE, 7'h20, 8'h10, 8'h55, cyc + 2, 1'b0});
      wait_start();
      req = 3'b000;
      dq.push_back('{3'b100, 1'b1, 8'h00, -1});
      pulse_done(1'b1, 8'h00);
      wait_idle();

      // Contention: all three held, expect 0,1,2,0 with the fixed done-to-start latency.
      set_fields(0, RW_WRITE, 7'h30, 8'h60, 8'hC0);
      set_fields(1, RW_WRITE, 7'h31, 8'h61, 8'hC1);
      set_fields(2, RW_WRITE, 7'h32, 8'h62, 8'hC2);
      req = 3'b111;
      sq.push_back('{3'b001, RW_WRITE, 7'h30, 8'h60, 8'hC0, cyc + 2, 1'b0});
      for (int g = 0; g < 4; g++) begin
         wait_start();
         if (g == 3) req = 3'b000;
         dq.push_back('{3'b001 << (g % 3), 1'b0, 8'(8'h10 + g), -1});
         pulse_done(1'b0, 8'(8'h10 + g));
         if (g < 3) begin
            nxt = (g + 1) % 3;
            sq.push_back('{3'b001 << nxt, RW_WRITE, 7'(7'h30 + nxt), 8'(8'h60 + nxt),
                           8'(8'hC0 + nxt), -1, 1'b1});
         end
      end
      wait_idle();

      // Reset in WAIT: no done, outputs cleared, then index 0 wins first.
      req = 3'b100;
      sq.push_back('{3'b100, RW_WRITE, 7'h32, 8'h62, 8'hC2, cyc + 2, 1'b0});
      wait_start();
      req = 3'b000;
      repeat (3) @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_all_zero("reset_mid_wait");
      repeat (2) @(posedge clk); #1;
      reset = 1'b1;
      req = 3'b111;
      sq.push_back('{3'b001, RW_WRITE, 7'h30, 8'h60, 8'hC0, cyc + 2, 1'b0});
      wait_start();
      req = 3'b000;
      dq.push_back('{3'b001, 1'b0, 8'h77, -1});
      pulse_done(1'b0, 8'h77);
      wait_idle();

      // Master never answers.
      req = 3'b010;
      sq.push_back('{3'b010, RW_WRITE, 7'h31, 8'h61, 8'hC1, cyc + 2, 1'b0});
      wait_start();
      req = 3'b000;
      m_rd_data = 8'hEE;
      s = cyc;
`ifdef I2C_ARB_TIMEOUT_EN
      dq.push_back('{3'b010, 1'b1, 8'h00, s + TO});
      seen = 1'b0;
      for (int k = 0; k < TO + 50; k++) begin
         @(negedge clk);
         if (|done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("timeout_done_missing", 64'd0, 64'd1);
      m_rd_data = 8'h00;
      wait_idle();
`else
      seen = 1'b0;
      repeat (10000) @(negedge clk);
      check("still_waiting_grant", grant, 3'b010);
      check("still_waiting_cycles", cyc - s, 10000);
      m_rd_data = 8'h00;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) @(posedge clk); #1;
      reset = 1'b1;
`endif

      repeat (5) @(posedge clk);
      check("start_queue_empty", sq.size(), 0);
      check("done_queue_empty", dq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
